sr_capture: RTL and testbench

SR_CAPTURE -- requirements
Module: sr_capture

---
 rtl/sr_capture.sv | 125 ++++++++++++
 tb/tb_sr_capture.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sr_capture.sv
`default_nettype none
// ============================================================================
// Module   : sr_capture
// Purpose  : Captures frames from a '595-style serial shift-register bus.
// Revision : 1.0 - initial release
// ============================================================================
module sr_capture #(
    parameter int WIDTH = 49,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             mr,
    output logic [WIDTH-1:0] frame,
    output logic             frame_valid,
    output logic [CNT_W-1:0] bit_count,
    output logic             len_err,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_LATCHED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_width_cnt = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_one_cnt   = CNT_W'(1);

    logic             r_ds_meta,   r_ds_sync;
    logic             r_mr_meta,   r_mr_sync;
    logic             r_shcp_meta, r_shcp_sync, r_shcp_prev;
    logic             r_stcp_meta, r_stcp_sync, r_stcp_prev;
    logic [WIDTH-1:0] r_sreg;
    state_t           r_state;

    logic             w_shcp_edge;
    logic             w_stcp_edge;
    logic             w_latch;
    logic             w_ovf_set;
    logic [WIDTH-1:0] w_sreg_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;

    // Clock-line synchronizers reset high so a line held high through reset
    // does not look like a rising edge once reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ds_meta   <= 1'b0;
            r_ds_sync   <= 1'b0;
            r_mr_meta   <= 1'b0;
            r_mr_sync   <= 1'b0;
            r_shcp_meta <= 1'b1;
            r_shcp_sync <= 1'b1;
            r_shcp_prev <= 1'b1;
            r_stcp_meta <= 1'b1;
            r_stcp_sync <= 1'b1;
            r_stcp_prev <= 1'b1;
        end else begin
            r_ds_meta   <= ds;
            r_ds_sync   <= r_ds_meta;
            r_mr_meta   <= mr;
            r_mr_sync   <= r_mr_meta;
            r_shcp_meta <= shcp;
            r_shcp_sync <= r_shcp_meta;
            r_shcp_prev <= r_shcp_sync;
            r_stcp_meta <= stcp;
            r_stcp_sync <= r_stcp_meta;
            r_stcp_prev <= r_stcp_sync;
        end
    end

    always_comb begin
        w_shcp_edge = r_shcp_sync & ~r_shcp_prev;
        w_stcp_edge = r_stcp_sync & ~r_stcp_prev;
        w_sreg_next = w_shcp_edge ? {r_ds_sync, r_sreg[WIDTH-1:1]} : r_sreg;
        w_cnt_inc   = (bit_count == {CNT_W{1'b1}}) ? bit_count : bit_count + c_one_cnt;
        w_cnt_next  = bit_count;
        if (w_shcp_edge) begin
            w_cnt_next = (r_state == ST_LATCHED) ? c_one_cnt : w_cnt_inc;
        end
        // Shifting past a full frame; a restart from LATCHED never overflows.
        w_ovf_set = w_shcp_edge && (r_state != ST_LATCHED) && (bit_count >= c_width_cnt);
        w_latch   = w_stcp_edge && (r_state != ST_LATCHED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            bit_count   <= '0;
            len_err     <= 1'b0;
            overflow    <= 1'b0;
            r_state     <= ST_IDLE;
        end else if (!r_mr_sync) begin
            r_sreg      <= '0;
            frame_valid <= 1'b0;
            bit_count   <= '0;
            overflow    <= 1'b0;
            r_state     <= ST_IDLE;
        end else begin
            frame_valid <= 1'b0;
            r_sreg      <= w_sreg_next;
            bit_count   <= w_cnt_next;
            if (w_ovf_set) begin
                overflow <= 1'b1;
            end
            // Latch sees the post-shift register and count when edges coincide.
            if (w_latch) begin
                frame       <= w_sreg_next;
                frame_valid <= 1'b1;
                len_err     <= (w_cnt_next != c_width_cnt);
                r_state     <= ST_LATCHED;
            end else if (w_shcp_edge) begin
                r_state <= ST_SHIFT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_capture
// Purpose  : Directed self-checking bench for sr_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_capture;

    localparam int WIDTH = 49;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset, ds, shcp, stcp, mr;
    logic [WIDTH-1:0] frame;
    logic             frame_valid;
    logic [CNT_W-1:0] bit_count;
    logic             len_err, overflow;

    int compared   = 0;
    int mismatched = 0;
    int fv_cnt     = 0;
    int fv_base;

    logic [63:0] v1, v2, pat, exp3, frame_hold;

    sr_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ds          (ds),
        .shcp        (shcp),
        .stcp        (stcp),
        .mr          (mr),
        .frame       (frame),
        .frame_valid (frame_valid),
        .bit_count   (bit_count),
        .len_err     (len_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        tick(2);
        shcp = 1'b1;
        tick(2);
        shcp = 1'b0;
        tick(2);
    endtask

    task automatic shift_word(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) shift_bit(v[i]);
    endtask

    task automatic stcp_pulse();
        stcp = 1'b1;
        tick(4);
        stcp = 1'b0;
        tick(3);
    endtask

    initial begin
        v1  = 64'h1_2345_6789_ABCD;
        v2  = 64'h0_FEDC_BA98_7654;
        pat = 64'h335;
        reset = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; mr = 1'b1;
        tick(3);
        chk("rst_frame",    64'(frame),       64'h0);
        chk("rst_fv",       64'(frame_valid), 64'h0);
        chk("rst_count",    64'(bit_count),   64'h0);
        chk("rst_len_err",  64'(len_err),     64'h0);
        chk("rst_overflow", 64'(overflow),    64'h0);
        reset = 1'b0;
        tick(4);

        // Full 49-bit frame, with exact frame_valid timing after the stcp rise
        shift_word(v1, WIDTH);
        chk("full_count", 64'(bit_count), 64'd49);
        fv_base = fv_cnt;
        stcp = 1'b1;
        tick(2);
        chk("full_fv_early", 64'(frame_valid), 64'h0);
        tick(1);
        chk("full_fv_pulse", 64'(frame_valid), 64'h1);
        chk("full_frame",    64'(frame),       v1 & 64'h1_FFFF_FFFF_FFFF);
        chk("full_len_err",  64'(len_err),     64'h0);
        tick(1);
        chk("full_fv_drop",  64'(frame_valid), 64'h0);
        // Long stcp high, then a second rise while still LATCHED
        tick(18);
        stcp = 1'b0;
        tick(4);
        stcp_pulse();
        chk("relatch_pulses", 64'(fv_cnt - fv_base), 64'd1);
        chk("relatch_frame",  64'(frame), v1);

        // Short frame: count restarts at 1 from LATCHED, no clear in between
        exp3 = {15'h0, pat[9:0], v1[48:10]};
        fv_base = fv_cnt;
        shift_word(pat, 10);
        chk("short_count", 64'(bit_count), 64'd10);
        stcp_pulse();
        chk("short_pulses",  64'(fv_cnt - fv_base), 64'd1);
        chk("short_len_err", 64'(len_err),   64'h1);
        chk("short_frame",   64'(frame),     exp3);
        chk("short_count2",  64'(bit_count), 64'd10);

        // Clear, then overflow by one extra shift
        mr = 1'b0;
        tick(3);
        mr = 1'b1;
        tick(3);
        chk("clr_count", 64'(bit_count), 64'h0);
        shift_word(64'h1, WIDTH);
        chk("ovf_at_49",   64'(overflow),  64'h0);
        chk("ovf_count49", 64'(bit_count), 64'd49);
        shift_bit(1'b0);
        chk("ovf_set",     64'(overflow),  64'h1);
        chk("ovf_count50", 64'(bit_count), 64'd50);
        stcp_pulse();
        chk("ovf_frame",   64'(frame),    64'h0);
        chk("ovf_len_err", 64'(len_err),  64'h1);
        chk("ovf_sticky",  64'(overflow), 64'h1);

        // mr low after 20 shifts clears count/overflow in 3 clk; frame/len_err hold
        shift_word(v2, 20);
        chk("mr_pre_count", 64'(bit_count), 64'd20);
        mr = 1'b0;
        tick(2);
        chk("mr_count_2clk", 64'(bit_count), 64'd20);
        tick(1);
        chk("mr_count_3clk", 64'(bit_count), 64'h0);
        chk("mr_overflow",   64'(overflow),  64'h0);
        chk("mr_frame_hold", 64'(frame),     64'h0);
        chk("mr_len_hold",   64'(len_err),   64'h1);
        fv_base = fv_cnt;
        stcp_pulse();
        chk("mr_stcp_ignored", 64'(fv_cnt - fv_base), 64'h0);
        mr = 1'b1;
        tick(3);
        shift_word(v2, WIDTH);
        stcp_pulse();
        chk("after_mr_frame",   64'(frame),     v2);
        chk("after_mr_len_err", 64'(len_err),   64'h0);
        chk("after_mr_pulses",  64'(fv_cnt - fv_base), 64'd1);

        // Reset mid-frame with stcp high
        shift_word(v1, 5);
        stcp = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_frame", 64'(frame),     64'h0);
        chk("mid_rst_count", 64'(bit_count), 64'h0);
        chk("mid_rst_fv",    64'(frame_valid), 64'h0);
        tick(2);
        reset = 1'b0;
        fv_base = fv_cnt;
        tick(8);
        chk("post_rst_no_pulse", 64'(fv_cnt - fv_base), 64'h0);
        stcp = 1'b0;
        tick(3);
        stcp_pulse();
        chk("post_rst_pulse",   64'(fv_cnt - fv_base), 64'd1);
        chk("post_rst_len_err", 64'(len_err), 64'h1);
        chk("post_rst_frame",   64'(frame),   64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
